// File: rtl/adder_serial_core.sv
// adder_serial_core: multi-cycle A + B_INV + CIN adder, CHUNK bits per clock.
// Produces sum plus carry, signed-overflow, zero and negative flags.
module adder_serial_core #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B_INV,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             COUT,
    output logic             OVERFLOW,
    output logic             ZERO,
    output logic             NEGATIVE
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] KLAST = KW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]       state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] part_q;
    logic             carry_q;

    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] part_nx;
    logic             msb_c;
    logic             last;

    // Operands are shifted down each cycle, so the active slice is always the low CHUNK bits;
    // slice sums enter the partial result from the top and land in place after N shifts.
    always_comb begin
        slice_sum = {1'b0, a_q[CHUNK-1:0]}
                  + {1'b0, b_q[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_q};
        part_nx   = (part_q >> CHUNK)
                  | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        msb_c     = slice_sum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
        last      = (k_q == KLAST);
    end

    assign BUSY = (state_q == RUN);
    assign DONE = (state_q == FIN);

    // Control FSM, slice datapath and result/flag registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            part_q   <= '0;
            carry_q  <= 1'b0;
            RESULT   <= '0;
            COUT     <= 1'b0;
            OVERFLOW <= 1'b0;
            ZERO     <= 1'b0;
            NEGATIVE <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, FIN: begin
                    if (START) begin
                        a_q     <= A;
                        b_q     <= B_INV;
                        carry_q <= CIN;
                        k_q     <= '0;
                        part_q  <= '0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    part_q  <= part_nx;
                    carry_q <= slice_sum[CHUNK];
                    k_q     <= k_q + KW'(1);
                    if (last) begin
                        RESULT   <= part_nx;
                        COUT     <= slice_sum[CHUNK];
                        OVERFLOW <= msb_c ^ slice_sum[CHUNK];
                        ZERO     <= (part_nx == '0);
                        NEGATIVE <= part_nx[WIDTH-1];
                        state_q  <= FIN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_serial_core.sv
// tb_adder_serial_core: directed steps with a scoreboard of expected results.
// A DONE monitor pops and compares each completed operation.
module tb_adder_serial_core;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [31:0] A;
    logic [31:0] B_INV;
    logic        CIN;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;
    logic        COUT;
    logic        OVERFLOW;
    logic        ZERO;
    logic        NEGATIVE;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_done = 0;
    exp_t sb[$];
    int   done_cyc[$];
    exp_t last_exp;

    adder_serial_core #(.WIDTH(32), .CHUNK(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START),
        .A(A), .B_INV(B_INV), .CIN(CIN),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
        .COUT(COUT), .OVERFLOW(OVERFLOW),
        .ZERO(ZERO), .NEGATIVE(NEGATIVE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cycle counter used to time DONE pulses.
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic ci);
        exp_t m;
        logic [32:0] s;
        s   = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        m.r = s[31:0];
        m.c = s[32];
        m.v = (a[31] == b[31]) && (s[31] != a[31]);
        m.z = (s[31:0] == 32'd0);
        m.n = s[31];
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every DONE pulse must match the oldest expected result.
    always @(negedge CLK) begin
        if (RST_N && DONE) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL done_unexpected observed=%0h expected=none", RESULT);
            end else begin
                e = sb.pop_front();
                checks++;
                assert ({RESULT, COUT, OVERFLOW, ZERO, NEGATIVE} === e) else begin
                    errors++;
                    $error("FAIL done_result observed=%0h/%b%b%b%b expected=%0h/%b%b%b%b",
                           RESULT, COUT, OVERFLOW, ZERO, NEGATIVE,
                           e.r, e.c, e.v, e.z, e.n);
                end
            end
            done_cyc.push_back(cyc);
            n_done++;
        end
    end

    task automatic wait_dones(input int target, input string tag);
        int i;
        for (i = 0; i < 60 && n_done < target; i++) @(negedge CLK);
        #1;
        chk({tag, "_done_count"}, 64'(n_done), 64'(target));
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input string tag);
        int busy_n;
        int target;
        exp_t e;
        busy_n = 0;
        target = n_done + 1;
        e = model(a, b, ci);
        @(posedge CLK); #1;
        START = 1'b1; A = a; B_INV = b; CIN = ci;
        sb.push_back(e);
        last_exp = e;
        @(posedge CLK); #1;
        START = 1'b0;
        A = ~a; B_INV = ~b; CIN = ~ci;
        for (int i = 0; i < 20 && !DONE; i++) begin
            if (BUSY) busy_n++;
            @(posedge CLK); #1;
        end
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd4);
        wait_dones(target, tag);
    endtask

    initial begin
        int base;
        exp_t e2;
        exp_t e3;
        RST_N = 1'b0; START = 1'b0; A = '0; B_INV = '0; CIN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy",   64'(BUSY), 64'd0);
        chk("rst_done",   64'(DONE), 64'd0);
        chk("rst_result", 64'(RESULT), 64'd0);
        chk("rst_flags",  64'({COUT, OVERFLOW, ZERO, NEGATIVE}), 64'd0);
        RST_N = 1'b1;

        // Subtract 5 - 3.
        run_op(32'd5, 32'hFFFF_FFFC, 1'b1, "sub");

        // Reset two cycles into a run.
        base = n_done;
        @(posedge CLK); #1;
        START = 1'b1; A = 32'd1; B_INV = 32'd1; CIN = 1'b0;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("mid_busy_before", 64'(BUSY), 64'd1);
        RST_N = 1'b0;
        #1;
        chk("mid_busy",   64'(BUSY), 64'd0);
        chk("mid_done",   64'(DONE), 64'd0);
        chk("mid_result", 64'(RESULT), 64'd0);
        chk("mid_flags",  64'({COUT, OVERFLOW, ZERO, NEGATIVE}), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        chk("mid_after_busy", 64'(BUSY), 64'd0);
        chk("mid_no_done", 64'(n_done), 64'(base));

        // Signed overflow and full carry chain.
        run_op(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, "ovf");
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "carry");

        // Back-to-back with START held high and operands changing mid-run.
        base = n_done;
        done_cyc.delete();
        e2 = model(32'h1234_5678, 32'h8765_4321, 1'b1);
        e3 = model(32'h8000_0000, 32'h8000_0000, 1'b0);
        @(posedge CLK); #1;
        START = 1'b1; A = 32'h00FF_00FF; B_INV = 32'h0001_0001; CIN = 1'b0;
        sb.push_back(model(32'h00FF_00FF, 32'h0001_0001, 1'b0));
        @(posedge CLK); #1;
        A = 32'h1234_5678; B_INV = 32'h8765_4321; CIN = 1'b1;
        sb.push_back(e2);
        repeat (5) @(posedge CLK);
        #1;
        chk("b2b_no_idle", 64'(BUSY), 64'd1);
        A = 32'h8000_0000; B_INV = 32'h8000_0000; CIN = 1'b0;
        sb.push_back(e3);
        last_exp = e3;
        repeat (5) @(posedge CLK);
        #1;
        chk("b2b_no_idle2", 64'(BUSY), 64'd1);
        START = 1'b0;
        A = '0; B_INV = '0;
        wait_dones(base + 3, "b2b");
        if (done_cyc.size() == 3) begin
            chk("b2b_gap1", 64'(done_cyc[1] - done_cyc[0]), 64'd5);
            chk("b2b_gap2", 64'(done_cyc[2] - done_cyc[1]), 64'd5);
        end else begin
            chk("b2b_done_pulses", 64'(done_cyc.size()), 64'd3);
        end

        // Result hold with START low.
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            chk("hold_result", 64'(RESULT), 64'(last_exp.r));
            chk("hold_flags", 64'({COUT, OVERFLOW, ZERO, NEGATIVE}),
                64'({last_exp.c, last_exp.v, last_exp.z, last_exp.n}));
            chk("hold_ctl", 64'({BUSY, DONE}), 64'd0);
        end
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
